// File: rtl/div_seq_pkg.sv
// Shared definitions for the divider sequencer: state encoding,
// nominal divider latency and the {remainder, quotient} field slices.
package div_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Typical launch-to-ready distance of the shared iterative divider.
    localparam int DIV_NOMINAL_LAT = 35;

    // Divider result layout: remainder in the upper word, quotient in the lower.
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

    function automatic logic [31:0] result_hi(input logic [63:0] res);
        return res[HI_MSB:HI_LSB];
    endfunction

    function automatic logic [31:0] result_lo(input logic [63:0] res);
        return res[LO_MSB:LO_LSB];
    endfunction

endpackage

// File: rtl/div_seq_ctrl.sv
// Sequencer between EX and the shared iterative divider. Launches DIV/DIVU,
// stalls EX while the divider runs, writes HI/LO once per instruction and
// annuls/drains the divider on a pipeline flush.
// Optional build macro DIV_ZERO_SHORTCUT_EN: a zero dividend or divisor
// completes in the launch cycle with HI=LO=0 without starting the divider.
module div_seq_ctrl
    import div_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_op1_i,
    input  logic [31:0] req_op2_i,
    input  logic        flush_i,
    input  logic        adv_i,
    output logic        stall_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] drain_cnt;
    logic             drain_last;
    logic [31:0]      op1_q;
    logic [31:0]      op2_q;
    logic             signed_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             retired_q;
    logic             launch;
    logic             zero_short;

`ifdef DIV_ZERO_SHORTCUT_EN
    assign zero_short = (req_op1_i == 32'd0) || (req_op2_i == 32'd0);
`else
    assign zero_short = 1'b0;
`endif

    // The instruction that just retired from DONE has left EX, so the cycle
    // after DONE never launches; resetn gates launch so reset forces outputs low.
    assign launch     = resetn && (state == ST_IDLE) && req_valid_i && !flush_i && !retired_q;
    assign drain_last = (drain_cnt == CNT_W'(DRAIN_CYCLES - 1));

    // Next-state selection; a flush in BUSY beats a same-cycle ready.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (launch) state_nxt = zero_short ? ST_DONE : ST_BUSY;
            ST_BUSY:  if (flush_i) state_nxt = ST_DRAIN;
                      else if (div_ready_i) state_nxt = ST_DONE;
            ST_DONE:  if (adv_i || flush_i) state_nxt = ST_IDLE;
            ST_DRAIN: if (drain_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Pipeline and divider handshake outputs; operands pass through in IDLE
    // and come from the launch-time copies afterwards.
    always_comb begin
        stall_o      = (state == ST_BUSY) || launch;
        div_start_o  = launch && !zero_short;
        div_annul_o  = (state == ST_DRAIN) || ((state == ST_BUSY) && flush_i);
        hilo_we_o    = (state == ST_DONE) && adv_i && !flush_i;
        div_op1_o    = op1_q;
        div_op2_o    = op2_q;
        div_signed_o = signed_q;
        if (state == ST_IDLE) begin
            div_op1_o    = req_op1_i & {32{resetn}};
            div_op2_o    = req_op2_i & {32{resetn}};
            div_signed_o = req_signed_i & resetn;
        end
        hi_o = hi_q;
        lo_o = lo_q;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Drain counter: cleared on annul, counts the cycles the divider needs to go idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drain_cnt <= '0;
        end else if ((state == ST_BUSY) && flush_i) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN) begin
            drain_cnt <= drain_last ? '0 : drain_cnt + CNT_W'(1);
        end
    end

    // Operand copies taken at launch so EX may change its buses while BUSY.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
        end else if (launch) begin
            op1_q    <= req_op1_i;
            op2_q    <= req_op2_i;
            signed_q <= req_signed_i;
        end
    end

    // HI/LO result register, loaded only from a non-flushed divider strobe or the zero shortcut.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (launch && zero_short) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if ((state == ST_BUSY) && div_ready_i && !flush_i) begin
            hi_q <= result_hi(div_result_i);
            lo_q <= result_lo(div_result_i);
        end
    end

    // Marks the IDLE cycle right after DONE so the departed instruction is not relaunched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) retired_q <= 1'b0;
        else         retired_q <= (state == ST_DONE) && (adv_i || flush_i);
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl; the bench itself plays the divider,
// returning hand-computed {remainder, quotient} values.
// Build with DIV_ZERO_SHORTCUT_EN defined to exercise the zero shortcut path.
module tb_div_seq_ctrl;
    import div_seq_pkg::*;

    logic        clk;
    logic        resetn;
    logic        req_valid_i;
    logic        req_signed_i;
    logic [31:0] req_op1_i;
    logic [31:0] req_op2_i;
    logic        flush_i;
    logic        adv_i;
    logic        stall_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    div_seq_ctrl #(.DRAIN_CYCLES(3), .CNT_W(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid_i  (req_valid_i),
        .req_signed_i (req_signed_i),
        .req_op1_i    (req_op1_i),
        .req_op2_i    (req_op2_i),
        .flush_i      (flush_i),
        .adv_i        (adv_i),
        .stall_o      (stall_o),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic sg, input logic [31:0] a, input logic [31:0] b);
        step();
        req_valid_i  = 1'b1;
        req_signed_i = sg;
        req_op1_i    = a;
        req_op2_i    = b;
        adv_i        = 1'b0;
        #1;
    endtask

    // Full divider round trip: launch, BUSY for the nominal latency, ready, retire.
    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int bad;
        apply_stimulus(sg, a, b);
        check_output("launch_start", div_start_o, 1'b1);
        check_output("launch_stall", stall_o, 1'b1);
        check_output("launch_signed", div_signed_o, sg);
        bad = 0;
        for (int i = 0; i < DIV_NOMINAL_LAT - 1; i++) begin
            step();
            #1;
            if (stall_o !== 1'b1 || div_start_o !== 1'b0 || hilo_we_o !== 1'b0) bad++;
        end
        check_output("busy_stall_bad_cycles", bad, 0);
        step();
        div_ready_i  = 1'b1;
        div_result_i = {exp_hi, exp_lo};
        #1;
        check_output("ready_cycle_we", hilo_we_o, 1'b0);
        step();
        div_ready_i  = 1'b0;
        div_result_i = 64'hDEAD_BEEF_0BAD_F00D;
        adv_i        = 1'b1;
        #1;
        check_output("done_stall", stall_o, 1'b0);
        check_output("done_we", hilo_we_o, 1'b1);
        check_output("done_hi", hi_o, exp_hi);
        check_output("done_lo", lo_o, exp_lo);
        step();
        adv_i = 1'b0;
        #1;
        check_output("after_done_no_relaunch", div_start_o, 1'b0);
        check_output("after_done_we", hilo_we_o, 1'b0);
        req_valid_i = 1'b0;
    endtask

    initial begin
        int bad;
        int annul_cnt;
        int we_cnt;
        resetn       = 1'b0;
        req_valid_i  = 1'b1;
        req_signed_i = 1'b1;
        req_op1_i    = 32'd123;
        req_op2_i    = 32'd7;
        flush_i      = 1'b0;
        adv_i        = 1'b0;
        div_result_i = '0;
        div_ready_i  = 1'b0;
        #3;
        check_output("reset_stall", stall_o, 1'b0);
        check_output("reset_start", div_start_o, 1'b0);
        check_output("reset_annul", div_annul_o, 1'b0);
        check_output("reset_op1", div_op1_o, 32'd0);
        check_output("reset_signed", div_signed_o, 1'b0);
        check_output("reset_hi", hi_o, 32'd0);
        check_output("reset_lo", lo_o, 32'd0);
        req_valid_i  = 1'b0;
        req_signed_i = 1'b0;
        step();
        resetn = 1'b1;

        $display("[TB] DIVU 100/7");
        do_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("[TB] DIV -7/2");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        $display("[TB] DIVU 5/0");
`ifdef DIV_ZERO_SHORTCUT_EN
        apply_stimulus(1'b0, 32'd5, 32'd0);
        adv_i = 1'b1;
        #0;
        check_output("zero_start", div_start_o, 1'b0);
        check_output("zero_stall", stall_o, 1'b1);
        step();
        #1;
        check_output("zero_we", hilo_we_o, 1'b1);
        check_output("zero_stall_done", stall_o, 1'b0);
        check_output("zero_hi", hi_o, 32'd0);
        check_output("zero_lo", lo_o, 32'd0);
        check_output("zero_start_done", div_start_o, 1'b0);
        step();
        req_valid_i = 1'b0;
        adv_i       = 1'b0;
`else
        do_div(1'b0, 32'd5, 32'd0, 32'd0, 32'd0);
`endif

        $display("[TB] result held in DONE");
        apply_stimulus(1'b0, 32'd20, 32'd6);
        check_output("hold_start", div_start_o, 1'b1);
        for (int i = 0; i < 3; i++) step();
        req_op1_i = 32'h0000_DEAD;
        #1;
        check_output("busy_op1_held", div_op1_o, 32'd20);
        step();
        div_ready_i  = 1'b1;
        div_result_i = {32'd2, 32'd3};
        step();
        div_ready_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (stall_o !== 1'b0 || hilo_we_o !== 1'b0 || div_start_o !== 1'b0 ||
                hi_o !== 32'd2 || lo_o !== 32'd3) bad++;
            step();
        end
        check_output("hold_bad_cycles", bad, 0);
        adv_i = 1'b1;
        #1;
        check_output("hold_release_we", hilo_we_o, 1'b1);
        step();
        adv_i = 1'b0;
        #1;
        check_output("hold_no_relaunch", div_start_o, 1'b0);
        check_output("hold_no_second_we", hilo_we_o, 1'b0);
        req_valid_i = 1'b0;

        $display("[TB] flush during BUSY");
        apply_stimulus(1'b0, 32'd1000, 32'd10);
        for (int i = 0; i < 10; i++) step();
        flush_i      = 1'b1;
        div_ready_i  = 1'b1;
        div_result_i = {32'hAAAA_AAAA, 32'h5555_5555};
        #1;
        annul_cnt = (div_annul_o === 1'b1) ? 1 : 0;
        we_cnt    = (hilo_we_o === 1'b1) ? 1 : 0;
        step();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (div_annul_o === 1'b1) annul_cnt++;
            if (hilo_we_o === 1'b1) we_cnt++;
            if (stall_o !== 1'b0 || div_start_o !== 1'b0) bad++;
            step();
            div_ready_i = (i == 0);
        end
        div_ready_i = 1'b0;
        check_output("flush_annul_cycles", annul_cnt, 4);
        check_output("flush_we_count", we_cnt, 0);
        check_output("flush_drain_bad", bad, 0);
        check_output("flush_hi_kept", hi_o, 32'd2);
        check_output("flush_lo_kept", lo_o, 32'd3);
        do_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3);

        $display("[TB] reset during BUSY");
        apply_stimulus(1'b0, 32'd77, 32'd7);
        for (int i = 0; i < 3; i++) step();
        resetn = 1'b0;
        #1;
        check_output("mid_reset_stall", stall_o, 1'b0);
        check_output("mid_reset_start", div_start_o, 1'b0);
        check_output("mid_reset_annul", div_annul_o, 1'b0);
        check_output("mid_reset_op1", div_op1_o, 32'd0);
        check_output("mid_reset_lo", lo_o, 32'd0);
        req_valid_i = 1'b0;
        step();
        resetn = 1'b1;
        do_div(1'b0, 32'd8, 32'd2, 32'd0, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
